// File: rtl/fetch_decode_skid_reg_if.sv
// Handshake bundle between fetch, the IF/ID register and decode.
// The master view belongs to the surrounding pipeline, which drives the fetch
// offer and the decode ready. The slave view belongs to the IF/ID register.
interface fetch_decode_skid_reg_if #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 32
);

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [ADDR_W-1:0]  in_pc_plus_4;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc_plus_4;

  modport master (
    output in_valid,
    output in_instr,
    output in_pc_plus_4,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_instr,
    input  out_pc_plus_4
  );

  modport slave (
    input  in_valid,
    input  in_instr,
    input  in_pc_plus_4,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_instr,
    output out_pc_plus_4
  );

endinterface

// File: rtl/fetch_decode_skid_reg.sv
// IF/ID pipeline register with a two-entry skid buffer.
// in_ready is taken straight from a flop, so fetch never sees a combinational
// path from decode's ready. The second entry absorbs the word that was already
// in flight when decode stalled, which keeps one word per cycle flowing.
// While nothing is held, decode sees NOP_INSTR and a zero PC+4.
module fetch_decode_skid_reg #(
  parameter int                 INSTR_W   = 32,
  parameter int                 ADDR_W    = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h00000013),
  parameter int                 CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  fetch_decode_skid_reg_if.slave        bus,
  output logic [CNT_W-1:0]              stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    BOTH  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] headInstr_q, headInstr_d;
  logic [ADDR_W-1:0]  headPc_q, headPc_d;
  logic [INSTR_W-1:0] skidInstr_q, skidInstr_d;
  logic [ADDR_W-1:0]  skidPc_q, skidPc_d;
  logic               inReady_q, inReady_d;
  logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;

  logic outValid;
  logic accept;
  logic drain;

  assign outValid = (state_q != EMPTY);
  assign accept   = bus.in_valid & inReady_q;
  assign drain    = outValid & bus.out_ready;

  // Next-state, data steering and registered-ready decision; flush overrides the transition last.
  always_comb begin
    state_d     = state_q;
    headInstr_d = headInstr_q;
    headPc_d    = headPc_q;
    skidInstr_d = skidInstr_q;
    skidPc_d    = skidPc_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = MAIN;
          headInstr_d = bus.in_instr;
          headPc_d    = bus.in_pc_plus_4;
        end
      end
      MAIN: begin
        if (accept && drain) begin
          headInstr_d = bus.in_instr;
          headPc_d    = bus.in_pc_plus_4;
        end else if (accept) begin
          state_d     = BOTH;
          skidInstr_d = bus.in_instr;
          skidPc_d    = bus.in_pc_plus_4;
        end else if (drain) begin
          state_d     = EMPTY;
        end
      end
      BOTH: begin
        if (drain) begin
          state_d     = MAIN;
          headInstr_d = skidInstr_q;
          headPc_d    = skidPc_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (flush) begin
      state_d = EMPTY;
    end

    inReady_d = (state_d != BOTH);
  end

  // Saturating count of cycles where decode holds off a valid word; flush leaves it alone.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (outValid && !bus.out_ready && (stallCnt_q != {CNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
  end

  // State, held entries, ready flag and stall counter; reset empties the stage immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      headInstr_q <= NOP_INSTR;
      headPc_q    <= '0;
      skidInstr_q <= NOP_INSTR;
      skidPc_q    <= '0;
      inReady_q   <= 1'b1;
      stallCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      headInstr_q <= headInstr_d;
      headPc_q    <= headPc_d;
      skidInstr_q <= skidInstr_d;
      skidPc_q    <= skidPc_d;
      inReady_q   <= inReady_d;
      stallCnt_q  <= stallCnt_d;
    end
  end

  assign bus.in_ready      = inReady_q;
  assign bus.out_valid     = outValid;
  assign bus.out_instr     = outValid ? headInstr_q : NOP_INSTR;
  assign bus.out_pc_plus_4 = outValid ? headPc_q : '0;
  assign stall_cnt         = stallCnt_q;

endmodule
